// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single-port synchronous data memory between the CPU load/store
// path (cpu_*) and the debug / program-loader path (dbg_*). A winning
// request is latched in IDLE, presented to the memory for exactly one cycle
// (ACCESS), read data is captured one cycle later (CAPTURE), and the owner
// receives a one-cycle acknowledge (DONE).
//
// Build option:
//   DMEM_ARB_ROUND_ROBIN_EN  defined   : simultaneous requests are granted to
//                                        the port that did not win last time.
//                            undefined : fixed priority, cpu wins every tie.
//
// Handshake: a requester raises <p>_req with stable <p>_we/<p>_addr/
//   <p>_wdata and holds <p>_req until the single-cycle <p>_ack pulse. The
//   request fields are latched on the grant edge, so they may change after
//   it. A req still high on the edge after ack is taken as a new request.
//
// Ports:
//   clock, reset              system clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata     CPU request
//   cpu_rdata, cpu_ack        CPU read data (registered), completion pulse
//   cpu_stall                 cpu_req & ~cpu_ack (fetch-stage stall)
//   dbg_req/we/addr/wdata     debug request
//   dbg_rdata, dbg_ack        debug read data (registered), completion pulse
//   mem_we/addr/wdata         memory request (address/data from latches)
//   mem_rdata                 memory read data, valid cycle after address
//   busy                      high whenever the FSM is not in IDLE
//   fsm_state                 current FSM state (observation only)
//   last_owner                owner of the most recent grant (0=cpu, 1=dbg)
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_ack,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [1:0]            fsm_state,
  output logic                  last_owner
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  state_t                r_state;
  logic                  r_owner;
  logic                  r_last_owner;
  logic                  r_we_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [DATA_WIDTH-1:0] r_wdata_q;
  logic                  r_mem_we;
  logic                  r_cpu_ack;
  logic                  r_dbg_ack;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_dbg_rdata;

  logic                  w_any_req;
  logic                  w_grant;
  logic                  w_win_we;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_wdata;

  assign w_any_req = cpu_req | dbg_req;

  // Winner selection; only consulted while the FSM sits in IDLE.
  always_comb begin
    w_grant = OWN_CPU;
    if (cpu_req && dbg_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      // last_owner resets to dbg, so the first tie goes to cpu.
      w_grant = ~r_last_owner;
`else
      w_grant = OWN_CPU;
`endif
    end else if (dbg_req) begin
      w_grant = OWN_DBG;
    end
  end

  always_comb begin
    w_win_we    = cpu_we;
    w_win_addr  = cpu_addr;
    w_win_wdata = cpu_wdata;
    if (w_grant == OWN_DBG) begin
      w_win_we    = dbg_we;
      w_win_addr  = dbg_addr;
      w_win_wdata = dbg_wdata;
    end
  end

  // Single sequencer. mem_we and the acks are registered so that they are
  // glitch-free and drop immediately with the asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_DBG;
      r_we_q       <= 1'b0;
      r_addr_q     <= '0;
      r_wdata_q    <= '0;
      r_mem_we     <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_dbg_ack    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner      <= w_grant;
            r_last_owner <= w_grant;
            r_we_q       <= w_win_we;
            r_addr_q     <= w_win_addr;
            r_wdata_q    <= w_win_wdata;
            r_mem_we     <= w_win_we;
            r_state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_mem_we <= 1'b0;
          if (r_we_q) begin
            // Writes need no capture cycle: acknowledge directly.
            r_cpu_ack <= (r_owner == OWN_CPU);
            r_dbg_ack <= (r_owner == OWN_DBG);
            r_state   <= S_DONE;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // mem_rdata now reflects the address presented during ACCESS.
          if (r_owner == OWN_CPU) begin
            r_cpu_rdata <= mem_rdata;
          end else begin
            r_dbg_rdata <= mem_rdata;
          end
          r_cpu_ack <= (r_owner == OWN_CPU);
          r_dbg_ack <= (r_owner == OWN_DBG);
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_cpu_ack <= 1'b0;
          r_dbg_ack <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata  = r_cpu_rdata;
  assign dbg_rdata  = r_dbg_rdata;
  assign cpu_ack    = r_cpu_ack;
  assign dbg_ack    = r_dbg_ack;
  assign cpu_stall  = cpu_req & ~r_cpu_ack;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_addr_q;
  assign mem_wdata  = r_wdata_q;
  assign busy       = (r_state != S_IDLE);
  assign fsm_state  = r_state;
  assign last_owner = r_last_owner;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Directed bench for dmem_port_arbiter with a behavioural one-cycle-latency
// synchronous memory. Inputs are driven 1 ns after the rising edge and
// outputs are sampled at that same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clock;
  logic          reset;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_stall;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_ack;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic [1:0]    fsm_state;
  logic          last_owner;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .cpu_stall  (cpu_stall),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_rdata  (dbg_rdata),
    .dbg_ack    (dbg_ack),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .fsm_state  (fsm_state),
    .last_owner (last_owner)
  );

  // Clock / memory model
  initial clock = 1'b0;
  always #5 clock = ~clock;

  bit [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Driver: issue one request on a port, wait (bounded) for its ack,
  // then release req and let the FSM return to IDLE.
  task automatic do_access(input bit is_dbg, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, output logic [DW-1:0] rd,
                           output int lat);
    rd  = '0;
    lat = 0;
    if (is_dbg) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (is_dbg ? dbg_ack : cpu_ack) begin
        rd = is_dbg ? dbg_rdata : cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if ({cpu_ack, dbg_ack, mem_we} !== 3'b000) $display("FAIL reset_ack_we: got %b want 000", {cpu_ack, dbg_ack, mem_we}); else n_pass++;
    n_checks++; if (mem_addr !== 14'h0 || mem_wdata !== 32'h0) $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata); else n_pass++;
    n_checks++; if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) $display("FAIL reset_rdata: got %h/%h want 0/0", cpu_rdata, dbg_rdata); else n_pass++;
    n_checks++; if (last_owner !== 1'b1) $display("FAIL reset_last_owner: got %b want 1", last_owner); else n_pass++;
    n_checks++; if (fsm_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", fsm_state); else n_pass++;
  endtask

  task automatic test_cpu_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (cpu_stall !== 1'b1) $display("FAIL wr_stall_idle: got %b want 1", cpu_stall); else n_pass++;
    tick(); // ACCESS
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 14'h0010 || mem_wdata !== 32'hDEADBEEF)
      $display("FAIL wr_access_bus: got we=%b a=%h d=%h want 1/0010/deadbeef", mem_we, mem_addr, mem_wdata); else n_pass++;
    n_checks++; if (cpu_ack !== 1'b0 || cpu_stall !== 1'b1 || busy !== 1'b1)
      $display("FAIL wr_access_ctl: got ack=%b stall=%b busy=%b want 0/1/1", cpu_ack, cpu_stall, busy); else n_pass++;
    tick(); // DONE
    n_checks++; if (cpu_ack !== 1'b1 || mem_we !== 1'b0 || cpu_stall !== 1'b0)
      $display("FAIL wr_done: got ack=%b we=%b stall=%b want 1/0/0", cpu_ack, mem_we, cpu_stall); else n_pass++;
    n_checks++; if (last_owner !== 1'b0) $display("FAIL wr_last_owner: got %b want 0", last_owner); else n_pass++;
    cpu_req = 1'b0;
    tick(); // IDLE
    n_checks++; if (cpu_ack !== 1'b0 || busy !== 1'b0) $display("FAIL wr_idle: got ack=%b busy=%b want 0/0", cpu_ack, busy); else n_pass++;
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010; cpu_wdata = 32'h0;
    tick(); // ACCESS
    n_checks++; if (mem_we !== 1'b0 || mem_addr !== 14'h0010) $display("FAIL rd_access: got we=%b a=%h want 0/0010", mem_we, mem_addr); else n_pass++;
    tick(); // CAPTURE
    n_checks++; if (cpu_ack !== 1'b0) $display("FAIL rd_capture_ack: got %b want 0", cpu_ack); else n_pass++;
    tick(); // DONE
    n_checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) $display("FAIL rd_done: got ack=%b d=%h want 1/deadbeef", cpu_ack, cpu_rdata); else n_pass++;
    n_checks++; if (dbg_rdata !== 32'h0 || dbg_ack !== 1'b0) $display("FAIL rd_dbg_quiet: got d=%h ack=%b want 0/0", dbg_rdata, dbg_ack); else n_pass++;
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_latched_fields();
    logic [DW-1:0] rd;
    int lat;
    do_access(1'b0, 1'b1, 14'h3FFF, 32'h12345678, rd, lat);
    n_checks++; if (lat !== 2) $display("FAIL latch_wr_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL latch_wr_keeps_rdata: got %h want deadbeef", cpu_rdata); else n_pass++;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010;
    tick(); // ACCESS
    cpu_addr = 14'h3FFF;
    #1;
    n_checks++; if (mem_addr !== 14'h0010) $display("FAIL latch_addr: got %h want 0010", mem_addr); else n_pass++;
    tick();
    tick(); // DONE
    n_checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) $display("FAIL latch_data: got ack=%b d=%h want 1/deadbeef", cpu_ack, cpu_rdata); else n_pass++;
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_tie();
    bit exp_dbg;
    bit seen;
    apply_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0020; cpu_wdata = 32'hC0DE0000;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 14'h3FFF; dbg_wdata = 32'h0;
    for (int r = 0; r < 4; r++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      exp_dbg = r[0];
`else
      exp_dbg = 1'b0;
`endif
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (busy) begin seen = 1'b1; break; end
      end
      n_checks++; if (!seen || last_owner !== exp_dbg || mem_we !== !exp_dbg)
        $display("FAIL tie_grant_%0d: got seen=%b owner=%b we=%b want 1/%b/%b", r, seen, last_owner, mem_we, exp_dbg, !exp_dbg); else n_pass++;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (cpu_ack || dbg_ack) begin seen = 1'b1; break; end
      end
      n_checks++; if (!seen || dbg_ack !== exp_dbg || cpu_ack !== !exp_dbg)
        $display("FAIL tie_ack_%0d: got seen=%b cpu=%b dbg=%b want 1/%b/%b", r, seen, cpu_ack, dbg_ack, !exp_dbg, exp_dbg); else n_pass++;
      if (exp_dbg) begin
        n_checks++; if (dbg_rdata !== 32'h12345678) $display("FAIL tie_dbg_rdata_%0d: got %h want 12345678", r, dbg_rdata); else n_pass++;
      end
      cpu_wdata = cpu_wdata + 32'h1;
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL tie_idle: got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd;
    int lat;
    int acks;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0030; cpu_wdata = 32'hA5A5A5A5;
    tick(); // ACCESS
    reset = 1'b1;
    #1;
    n_checks++; if (mem_we !== 1'b0 || busy !== 1'b0 || cpu_ack !== 1'b0)
      $display("FAIL rstmid_immediate: got we=%b busy=%b ack=%b want 0/0/0", mem_we, busy, cpu_ack); else n_pass++;
    cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_ack) acks++;
    end
    n_checks++; if (acks !== 0) $display("FAIL rstmid_no_ack: got %0d want 0", acks); else n_pass++;
    do_access(1'b0, 1'b0, 14'h0030, 32'h0, rd, lat);
    n_checks++; if (lat !== 3 || rd !== 32'h0) $display("FAIL rstmid_after: got lat=%0d d=%h want 3/00000000", lat, rd); else n_pass++;
    do_access(1'b1, 1'b0, 14'h0010, 32'h0, rd, lat);
    n_checks++; if (lat !== 3 || rd !== 32'hDEADBEEF) $display("FAIL rstmid_dbg_read: got lat=%0d d=%h want 3/deadbeef", lat, rd); else n_pass++;
  endtask

  task automatic test_drop_req();
    int acks;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h3FFF;
    tick(); // ACCESS
    cpu_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cpu_ack) acks++;
    end
    n_checks++; if (acks !== 1) $display("FAIL drop_ack_count: got %0d want 1", acks); else n_pass++;
    n_checks++; if (busy !== 1'b0 || cpu_stall !== 1'b0) $display("FAIL drop_idle: got busy=%b stall=%b want 0/0", busy, cpu_stall); else n_pass++;
    n_checks++; if (cpu_rdata !== 32'h12345678) $display("FAIL drop_rdata: got %h want 12345678", cpu_rdata); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_latched_fields();
    test_tie();
    test_reset_mid();
    test_drop_req();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter and access sequencer for the single-port synchronous data memory of the Minisys-32 CPU. It shares the memory between the CPU load/store path (port `cpu`) and a debug/program-loader port (port `dbg`). It latches the winning request, drives the memory for one access, captures read data across the one-cycle memory latency, and returns a one-cycle acknowledge. The block sits between the `MemOrIO` address path and the data memory instance in `cpu_top`, and supplies a stall to the fetch stage.

## Interface
- `ADDR_WIDTH`, 14, word-address width presented to the memory
- `DATA_WIDTH`, 32, data word width

- `clock`  in  1  system clock (`cpuclk` output)
- `reset`  in  1  asynchronous, active-high reset
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_WIDTH  CPU word address
- `cpu_wdata`  in  DATA_WIDTH  CPU write data
- `cpu_rdata`  out  DATA_WIDTH  registered CPU read data
- `cpu_ack`  out  1  one-cycle completion pulse for CPU
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`, combinational
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_rdata`, `dbg_ack`  same directions, widths and meaning as the `cpu_` set, for the debug port
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid the cycle after the address is presented
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, DONE.
- IDLE: if there is no request, stay. Otherwise pick a winner. On the clock edge:
  - latch `owner`, `we_q`, `addr_q` and `wdata_q` from the winner;
  - go to ACCESS.
- ACCESS: `mem_addr = addr_q`, `mem_wdata = wdata_q` and `mem_we = we_q`, all for exactly this cycle. A write goes to DONE; a read goes to CAPTURE.
- CAPTURE: load `<owner>_rdata <= mem_rdata`, then go to DONE.
- DONE: `<owner>_ack = 1` for exactly this cycle, then go to IDLE unconditionally.
- `mem_addr` and `mem_wdata` outputs come from the `_q` registers; `mem_we` is 0 outside ACCESS.
- `cpu_rdata` and `dbg_rdata` hold their last captured value until that port's next read completes. A write never changes them.
- Requester fields may change after the grant edge without effect, because they are latched.
- Dropping `req` before `ack` is a protocol violation. The latched access still completes and `ack` still pulses.
- Arbitration applies only in IDLE. A sole requester always wins. Simultaneous requests are resolved per Configuration.
- `last_owner` updates on every grant.

## Timing
- Reset (asynchronous) forces:
  - state IDLE, `busy=0`, `cpu_ack=dbg_ack=0`, `mem_we=0`;
  - `mem_addr=0`, `mem_wdata=0`, `cpu_rdata=dbg_rdata=0`;
  - `last_owner=dbg`.
- Read latency, with `req` seen high in IDLE at edge E:
  - ACCESS in E+1;
  - CAPTURE in E+2;
  - DONE/`ack` in E+3, with `rdata` valid in the same cycle.
- Write latency: ACCESS in E+1 (`mem_we=1`), `ack` in E+2.
- The requester must deassert `req` or present a new request by the edge after `ack`. DONE always returns to IDLE, so a `req` still high at that edge is treated as a new request.
- Back-to-back throughput per port: one read every 4 cycles, one write every 3 cycles.
- Reset asserted mid-access: the access is abandoned, `mem_we` drops immediately and no `ack` is issued.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined: on simultaneous requests, grant the port that is not `last_owner`. The first tie after reset goes to `cpu`.
- Not defined: fixed priority, `cpu` always wins ties. `last_owner` is still tracked, but it does not affect the grant.

## Test plan
- Reset, then CPU write to 0x0010 of 0xDEADBEEF:
  - `mem_we=1`, `mem_addr=0x0010`, `mem_wdata=0xDEADBEEF` for exactly 1 cycle;
  - `cpu_ack` 2 cycles after the IDLE grant edge;
  - `cpu_stall` high until `ack`.
- CPU read of 0x0010, with memory returning 0xDEADBEEF:
  - `cpu_ack` at E+3 with `cpu_rdata=0xDEADBEEF`;
  - `dbg_rdata` stays 0.
- Debug read and CPU write raised in the same cycle, repeated back-to-back, with the macro defined: grants alternate cpu, dbg, cpu, dbg, with no write-enable while the dbg read is in ACCESS. With the macro undefined, cpu wins every tie.
- CPU read granted, then `cpu_addr` changed to 0x3FFF in the ACCESS cycle: `mem_addr` stays at the latched address, and data from that address is returned.
- Reset pulsed while in ACCESS of a write: `mem_we=0` and `busy=0` immediately, no `cpu_ack` follows, and a new request after release completes normally.
- `cpu_req` dropped in ACCESS: the access finishes, `cpu_ack` still pulses once, and the FSM returns to IDLE with `busy=0`.
